// File: rtl/cp0_regfile.sv
// MIPS32 coprocessor-0 register file: Count/Compare timer, Status/Cause/EPC,
// exception capture from MEM and the write-back CP0 write port.
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_dslot_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic       exc_take;
  logic       exc_eret;
  logic [4:0] exc_code;

  // Only the listed codes are real events; anything else nonzero is ignored.
  always_comb begin
    exc_take = 1'b0;
    exc_eret = 1'b0;
    exc_code = 5'd0;
    case (excepttype_i)
      32'h0000_0001: begin exc_take = 1'b1; exc_code = 5'd0;  end
      32'h0000_0008: begin exc_take = 1'b1; exc_code = 5'd8;  end
      32'h0000_000a: begin exc_take = 1'b1; exc_code = 5'd10; end
      32'h0000_000c: begin exc_take = 1'b1; exc_code = 5'd12; end
      32'h0000_000d: begin exc_take = 1'b1; exc_code = 5'd13; end
      32'h0000_000e: exc_eret = 1'b1;
      default: ;
    endcase
  end

  assign prid_o = PRID_VALUE;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_o     <= 32'd0;
      compare_o   <= 32'd0;
      status_o    <= 32'h1000_0000;
      cause_o     <= 32'd0;
      epc_o       <= 32'd0;
      config_o    <= CONFIG_VALUE;
      timer_int_o <= 1'b0;
    end else begin
      count_o        <= count_o + 32'd1;
      cause_o[15:10] <= int_i;
      if (compare_o != 32'd0 && count_o == compare_o)
        timer_int_o <= 1'b1;

      // Status/Cause/EPC software writes yield to any exception or eret this cycle.
      if (we_i) begin
        case (waddr_i)
          5'd9:  count_o <= wdata_i;
          5'd11: begin
            compare_o   <= wdata_i;
            timer_int_o <= 1'b0;
          end
          5'd12: if (!(exc_take || exc_eret)) status_o <= wdata_i;
          5'd13: if (!(exc_take || exc_eret)) begin
            cause_o[9:8]   <= wdata_i[9:8];
            cause_o[23:22] <= wdata_i[23:22];
          end
          5'd14: if (!(exc_take || exc_eret)) epc_o <= wdata_i;
          default: ;
        endcase
      end

      if (exc_take) begin
        if (!status_o[1]) begin
          epc_o       <= in_dslot_i ? inst_addr_i - 32'd4 : inst_addr_i;
          cause_o[31] <= in_dslot_i;
        end
        status_o[1]  <= 1'b1;
        cause_o[6:2] <= exc_code;
      end
      if (exc_eret)
        status_o[1] <= 1'b0;
    end
  end

  always_comb begin
    case (raddr_i)
      5'd9:    rdata_o = count_o;
      5'd11:   rdata_o = compare_o;
      5'd12:   rdata_o = status_o;
      5'd13:   rdata_o = cause_o;
      5'd14:   rdata_o = epc_o;
      5'd15:   rdata_o = prid_o;
      5'd16:   rdata_o = config_o;
      default: rdata_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: a driver pushes model predictions per cycle,
// an independent monitor pops and compares them after each rising edge.
module tb_cp0_regfile;

  localparam logic [31:0] PRID   = 32'h004c0102;
  localparam logic [31:0] CONFIG = 32'h00008000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr = '0;
  logic [31:0] rdata;
  logic [5:0]  intr = '0;
  logic [31:0] exc = '0;
  logic [31:0] iaddr = '0;
  logic        dslot = 1'b0;
  logic [31:0] count, compare, status, cause, epc, cfg, prid;
  logic        tint;

  cp0_regfile #(.PRID_VALUE(PRID), .CONFIG_VALUE(CONFIG)) dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata), .int_i(intr), .excepttype_i(exc),
    .inst_addr_i(iaddr), .in_dslot_i(dslot), .count_o(count),
    .compare_o(compare), .status_o(status), .cause_o(cause), .epc_o(epc),
    .config_o(cfg), .prid_o(prid), .timer_int_o(tint)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [5:0]  intr;
    logic [31:0] exc;
    logic [31:0] addr;
    logic        dslot;
  } stim_t;

  typedef struct {
    logic [31:0] count, compare, status, cause, epc, cfg, prid, rdata;
    logic        tint;
  } exp_t;

  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;

  // Reference model: architectural registers indexed by CP0 register number.
  logic [31:0] m [0:31];
  logic        m_tint;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.we = 1'b0; s.waddr = '0; s.wdata = '0; s.raddr = '0;
    s.intr = '0; s.exc = '0; s.addr = '0; s.dslot = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] readReg(input logic [4:0] a);
    if (a == 9 || (a >= 11 && a <= 16)) return m[a];
    return 32'd0;
  endfunction

  task automatic modelStep(input stim_t s);
    logic [31:0] o [0:31];
    bit is_exc, is_eret;
    int code;
    if (s.rst) begin
      m[9] = 0; m[11] = 0; m[12] = 32'h1000_0000; m[13] = 0; m[14] = 0;
      m[15] = PRID; m[16] = CONFIG; m_tint = 0;
      return;
    end
    o = m;
    is_exc = 1; is_eret = 0; code = 0;
    case (s.exc)
      1: code = 0;
      8: code = 8;
      10: code = 10;
      12: code = 12;
      13: code = 13;
      default: is_exc = 0;
    endcase
    if (s.exc == 14) is_eret = 1;
    m[9] = o[9] + 1;
    if (o[11] != 0 && o[9] == o[11]) m_tint = 1;
    if (s.we) begin
      if (s.waddr == 9) m[9] = s.wdata;
      if (s.waddr == 11) begin m[11] = s.wdata; m_tint = 0; end
      if (!is_exc && !is_eret) begin
        if (s.waddr == 12) m[12] = s.wdata;
        if (s.waddr == 14) m[14] = s.wdata;
        if (s.waddr == 13) begin
          m[13][9:8] = s.wdata[9:8];
          m[13][23:22] = s.wdata[23:22];
        end
      end
    end
    m[13][15:10] = s.intr;
    if (is_exc) begin
      if (o[12][1] == 0) begin
        m[14] = s.dslot ? s.addr - 4 : s.addr;
        m[13][31] = s.dslot;
      end
      m[12][1] = 1;
      m[13][6:2] = code[4:0];
    end
    if (is_eret) m[12][1] = 0;
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst = s.rst; we = s.we; waddr = s.waddr; wdata = s.wdata; raddr = s.raddr;
    intr = s.intr; exc = s.exc; iaddr = s.addr; dslot = s.dslot;
    modelStep(s);
    e.count = m[9]; e.compare = m[11]; e.status = m[12]; e.cause = m[13];
    e.epc = m[14]; e.prid = m[15]; e.cfg = m[16]; e.tint = m_tint;
    e.rdata = readReg(s.raddr);
    expq.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: one prediction per rising edge, sampled after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("count", count, e.count);
        checkOutput("compare", compare, e.compare);
        checkOutput("status", status, e.status);
        checkOutput("cause", cause, e.cause);
        checkOutput("epc", epc, e.epc);
        checkOutput("config", cfg, e.cfg);
        checkOutput("prid", prid, e.prid);
        checkOutput("timer_int", {31'd0, tint}, {31'd0, e.tint});
        checkOutput("rdata", rdata, e.rdata);
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [4:0] ra);
    stim_t s = idle();
    s.we = 1; s.waddr = a; s.wdata = d; s.raddr = ra;
    applyStimulus(s);
  endtask

  task automatic ex(input logic [31:0] code, input logic [31:0] a, input logic ds);
    stim_t s = idle();
    s.exc = code; s.addr = a; s.dslot = ds; s.raddr = 5'd14;
    applyStimulus(s);
  endtask

  initial begin
    stim_t s;
    logic [4:0] addrs [0:7];
    addrs[0] = 9; addrs[1] = 11; addrs[2] = 12; addrs[3] = 13;
    addrs[4] = 14; addrs[5] = 15; addrs[6] = 16; addrs[7] = 3;

    s = idle(); s.rst = 1;
    applyStimulus(s);
    applyStimulus(s);
    for (int r = 9; r <= 17; r++) begin
      s = idle(); s.raddr = r[4:0];
      applyStimulus(s);
    end

    // Timer: fire at count==compare, hold, then clear on a Compare write.
    wr(5'd9, 32'h10, 5'd9);
    wr(5'd11, 32'h14, 5'd11);
    repeat (8) applyStimulus(idle());
    wr(5'd11, 32'h100, 5'd11);
    repeat (2) applyStimulus(idle());

    // Count wrap with compare=0 never raises the timer.
    wr(5'd11, 32'h0, 5'd11);
    wr(5'd9, 32'hFFFF_FFFF, 5'd9);
    repeat (3) applyStimulus(idle());

    // Exceptions, delay slot, nesting, eret and write conflict.
    ex(32'h8, 32'h8000_0100, 1'b0);
    ex(32'he, 32'h0, 1'b0);
    ex(32'ha, 32'h8000_0104, 1'b1);
    ex(32'h8, 32'h8000_0200, 1'b0);
    ex(32'he, 32'h0, 1'b0);
    s = idle(); s.we = 1; s.waddr = 12; s.wdata = 0; s.exc = 32'hc;
    s.addr = 32'h8000_0300; s.raddr = 12;
    applyStimulus(s);
    wr(5'd13, 32'hFFFF_FFFF, 5'd13);
    wr(5'd15, 32'h1234_5678, 5'd15);
    wr(5'd16, 32'h1234_5678, 5'd16);
    ex(32'h3, 32'h8000_0400, 1'b1);

    for (int i = 0; i < 600; i++) begin
      int r;
      s = idle();
      s.rst = ($urandom_range(0, 249) == 0);
      s.intr = 6'($urandom);
      s.raddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 7)];
      s.we = ($urandom_range(0, 2) == 0);
      s.waddr = addrs[$urandom_range(0, 7)];
      s.wdata = $urandom;
      if (s.waddr == 11 && $urandom_range(0, 1) == 1)
        s.wdata = m[9] + 32'($urandom_range(1, 8));
      r = $urandom_range(0, 15);
      case (r)
        9: s.exc = 32'h1;
        10: s.exc = 32'h8;
        11: s.exc = 32'ha;
        12: s.exc = 32'hc;
        13: s.exc = 32'hd;
        14: s.exc = 32'he;
        15: s.exc = 32'h3;
        default: s.exc = 32'h0;
      endcase
      s.addr = $urandom & 32'hFFFF_FFFC;
      s.dslot = 1'($urandom);
      applyStimulus(s);
    end

    applyStimulus(idle());
    repeat (3) @(negedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
